// File: rtl/nv_irq_unit_pkg.sv
// ----------------------------------------------------------------------------
// nv_irq_unit_pkg
// Shared definitions for the non-vectored interrupt request unit: default line
// count and index width, the line-mask and line-index types, a packed view of
// the registered outputs, and a reference least-significant-set-bit helper.
// ----------------------------------------------------------------------------
package nv_irq_unit_pkg;

    localparam int NV_IRQ_LINES = 32;
    localparam int NV_IRQ_IDW   = 5;

    typedef logic [NV_IRQ_LINES-1:0] nvIrqMask_t;
    typedef logic [NV_IRQ_IDW-1:0]   nvIrqId_t;

    // Registered request/index pair as seen by the core.
    typedef struct packed {
        logic     request;
        nvIrqId_t id;
    } nvIrqOut_t;

    // Index of the lowest set bit of a full-width mask; 0 when the mask is
    // empty. Scans from the top so the lowest set bit is the final write.
    function automatic nvIrqId_t lsbIndex(input nvIrqMask_t vec);
        nvIrqId_t idx;
        idx = '0;
        for (int i = NV_IRQ_LINES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = nvIrqId_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/nv_irq_unit_if.sv
// ----------------------------------------------------------------------------
// nv_irq_unit_if
// Bundle of the signals between the register block / status collector and the
// non-vectored interrupt request unit.
//   reg_top_inner_nvIRQ : per-line enable mask (bit i enables line i)
//   IRQStatus           : per-line pending status, level-sensitive
//   nvIRQRequest        : registered request toward the core
//   nvIRQID             : registered index of the winning line
// master : the side driving mask/status and consuming the request
// slave  : the interrupt unit itself
// ----------------------------------------------------------------------------
interface nv_irq_unit_if
    import nv_irq_unit_pkg::*;
#(
    parameter int NLINES = NV_IRQ_LINES,
    parameter int IDW    = NV_IRQ_IDW
);

    logic [NLINES-1:0] reg_top_inner_nvIRQ;
    logic [NLINES-1:0] IRQStatus;
    logic              nvIRQRequest;
    logic [IDW-1:0]    nvIRQID;

    modport master (
        output reg_top_inner_nvIRQ,
        output IRQStatus,
        input  nvIRQRequest,
        input  nvIRQID
    );

    modport slave (
        input  reg_top_inner_nvIRQ,
        input  IRQStatus,
        output nvIRQRequest,
        output nvIRQID
    );

endinterface

// File: rtl/nv_irq_unit_prio_enc.sv
// ----------------------------------------------------------------------------
// nv_irq_prio_enc
// Purely combinational least-significant-set-bit priority encoder.
//   vec   in  NLINES : request vector, bit 0 has the highest priority
//   idx   out IDW    : index of the lowest set bit, 0 when vec is all zero
//   valid out 1      : OR-reduction of vec
// ----------------------------------------------------------------------------
module nv_irq_prio_enc
    import nv_irq_unit_pkg::*;
#(
    parameter int NLINES = NV_IRQ_LINES,
    parameter int IDW    = NV_IRQ_IDW
) (
    input  logic [NLINES-1:0] vec,
    output logic [IDW-1:0]    idx,
    output logic              valid
);

    // Walk from the top down so that the lowest set bit overwrites any higher
    // one; an empty vector leaves the default index of 0.
    always_comb begin
        idx = '0;
        for (int i = NLINES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDW'(i);
            end
        end
    end

    assign valid = |vec;

endmodule

// File: rtl/nv_irq_unit.sv
// ----------------------------------------------------------------------------
// nv_irq_unit
// Non-vectored interrupt request unit. Masks the per-line pending status with
// the non-vectored enable register, and registers both a single request and
// the index of the lowest-numbered enabled pending line. The outputs follow
// the inputs level-wise with one clock of latency; there is no hold or
// acknowledge.
//   clk    : system clock, rising-edge
//   rst    : synchronous active-high reset, clears request and index
//   irqBus : slave side of nv_irq_unit_if (mask/status in, request/ID out)
// ----------------------------------------------------------------------------
module nv_irq_unit
    import nv_irq_unit_pkg::*;
#(
    parameter int NLINES = NV_IRQ_LINES,
    parameter int IDW    = NV_IRQ_IDW
) (
    input  logic          clk,
    input  logic          rst,
    nv_irq_unit_if.slave  irqBus
);

    logic [NLINES-1:0] hit_p0;
    logic [IDW-1:0]    id_p0;
    logic              vld_p0;

    logic [IDW-1:0]    id_p1;
    logic              vld_p1;

    // ---- stage p0: combinational mask and priority encode ----
    assign hit_p0 = irqBus.IRQStatus & irqBus.reg_top_inner_nvIRQ;

    nv_irq_prio_enc #(
        .NLINES (NLINES),
        .IDW    (IDW)
    ) uPrioEnc (
        .vec   (hit_p0),
        .idx   (id_p0),
        .valid (vld_p0)
    );

    // ---- stage p1: output registers ----
    // The index is cleared along with the request so the core never sees a
    // stale line number straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            id_p1  <= '0;
        end else begin
            vld_p1 <= vld_p0;
            id_p1  <= id_p0;
        end
    end

    assign irqBus.nvIRQRequest = vld_p1;
    assign irqBus.nvIRQID      = id_p1;

endmodule

// File: tb/tb_nv_irq_unit.sv
// ----------------------------------------------------------------------------
// tb_nv_irq_unit
// Directed bench for nv_irq_unit with hand-computed expected outputs.
// ----------------------------------------------------------------------------
module tb_nv_irq_unit;
    import nv_irq_unit_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    nv_irq_unit_if #(.NLINES(32), .IDW(5)) irqBus ();

    nv_irq_unit #(.NLINES(32), .IDW(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .irqBus (irqBus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOut(input string tag, input logic req, input logic [4:0] id);
        check({tag, "_req"}, {31'b0, irqBus.nvIRQRequest}, {31'b0, req});
        check({tag, "_id"},  {27'b0, irqBus.nvIRQID},      {27'b0, id});
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset held with everything pending and enabled.
        rst = 1'b1;
        irqBus.reg_top_inner_nvIRQ = 32'hFFFF_FFFF;
        irqBus.IRQStatus           = 32'hFFFF_FFFF;
        cycle();
        checkOut("rst_hold0", 1'b0, 5'd0);
        cycle();
        checkOut("rst_hold1", 1'b0, 5'd0);
        cycle();
        checkOut("rst_hold2", 1'b0, 5'd0);

        rst = 1'b0;
        #1;
        checkOut("rst_rel_before_edge", 1'b0, 5'd0);
        cycle();
        checkOut("rst_release", 1'b1, 5'd0);

        // Pending but masked off.
        irqBus.reg_top_inner_nvIRQ = 32'h0000_0000;
        irqBus.IRQStatus           = 32'h0A00_0000;
        cycle();
        checkOut("mask0_a", 1'b0, 5'd0);
        irqBus.IRQStatus = 32'hAAAA_AAAA;
        cycle();
        checkOut("mask0_b", 1'b0, 5'd0);

        // Enable overlap: line 1 is the lowest enabled pending line.
        irqBus.reg_top_inner_nvIRQ = 32'h0000_0007;
        #1;
        checkOut("overlap_no_comb", 1'b0, 5'd0);
        cycle();
        checkOut("overlap_id1", 1'b1, 5'd1);
        irqBus.IRQStatus = 32'h0000_0005;
        cycle();
        checkOut("overlap_id0", 1'b1, 5'd0);

        // Priority hand-off from line 4 to line 31.
        irqBus.reg_top_inner_nvIRQ = 32'hFFFF_FFFF;
        irqBus.IRQStatus           = 32'h8000_0010;
        cycle();
        checkOut("handoff_id4", 1'b1, 5'd4);
        irqBus.IRQStatus = 32'h8000_0000;
        #1;
        checkOut("handoff_hold", 1'b1, 5'd4);
        cycle();
        checkOut("handoff_id31", 1'b1, 5'd31);

        // Simultaneous mask and status change.
        irqBus.reg_top_inner_nvIRQ = 32'h0000_0F00;
        irqBus.IRQStatus           = 32'h0000_0300;
        cycle();
        checkOut("simul_id8", 1'b1, 5'd8);

        // Deassert when the only enabled lines stop pending.
        irqBus.reg_top_inner_nvIRQ = 32'h0000_0007;
        irqBus.IRQStatus           = 32'hAAAA_AAAA;
        cycle();
        checkOut("deassert_pre", 1'b1, 5'd1);
        irqBus.IRQStatus = 32'h0A00_0000;
        cycle();
        checkOut("deassert_drop", 1'b0, 5'd0);

        // Mid-operation reset with unchanged inputs.
        irqBus.reg_top_inner_nvIRQ = 32'hFFFF_FFFF;
        irqBus.IRQStatus           = 32'h8000_0010;
        cycle();
        checkOut("midrst_pre", 1'b1, 5'd4);
        rst = 1'b1;
        cycle();
        checkOut("midrst_on", 1'b0, 5'd0);
        rst = 1'b0;
        cycle();
        checkOut("midrst_after", 1'b1, 5'd4);

        // Top line alone, then everything cleared.
        irqBus.IRQStatus = 32'h8000_0000;
        cycle();
        checkOut("top_line", 1'b1, 5'd31);
        irqBus.IRQStatus = 32'h0000_0000;
        cycle();
        checkOut("all_clear", 1'b0, 5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
